// File: rtl/ravan_key_pkg.sv
// Shared types, constants and helpers for the Ravan round key scheduler.
// Optional RAVAN_KEY_ZEROIZE_EN clears key material after DONE or abort.
package ravan_key_pkg;

  localparam int SLICE_W    = 64;
  localparam int NUM_SLICES = 8;
  localparam int KEY_W      = SLICE_W * NUM_SLICES;

  localparam logic [7:0] RC_SEED_DEF = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  function automatic logic [63:0] rotl64(
    input logic [63:0] x,
    input logic [5:0]  n
  );
    logic [127:0] t;
    t = {x, x} << n;
    return t[127:64];
  endfunction

  function automatic logic [63:0] rc_mix(
    input logic [7:0] c
  );
    return {c, 48'h0, c};
  endfunction

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] c
  );
    return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
  endfunction

endpackage

// File: rtl/ravan_rc_lfsr.sv
// 8-bit Fibonacci LFSR producing the per-round constant.
// Reloads its seed on load_seed, steps once per advance.
module ravan_rc_lfsr
  import ravan_key_pkg::*;
#(
  parameter logic [7:0] SEED = RC_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_seed,
  input  logic       advance,
  output logic [7:0] rc,
  output logic [7:0] rc_next
);

  assign rc_next = lfsr_step(rc);

  // round constant register: seed has priority over stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc <= SEED;
    end else if (load_seed) begin
      rc <= SEED;
    end else if (advance) begin
      rc <= rc_next;
    end
  end

endmodule

// File: rtl/ravan_round_key_scheduler.sv
// Captures eight key slices and streams NUM_ROUNDS round keys.
// Optional RAVAN_KEY_ZEROIZE_EN wipes bank and rk_data on DONE/abort.
module ravan_round_key_scheduler
  import ravan_key_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16,
  parameter logic [7:0]  RC_SEED    = RC_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [KEY_W-1:0] key_slices,
  input  logic             abort,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [63:0]      rk_data,
  output logic [5:0]       rk_index,
  output logic             rk_last,
  output logic             done
);

  localparam logic [5:0] LAST = 6'(NUM_ROUNDS - 1);

  state_t state, state_n;

  logic [NUM_SLICES-1:0][SLICE_W-1:0] bank;
  logic [5:0] r;
  logic [5:0] r_n;
  logic [7:0] rc;
  logic [7:0] rc_next;
  logic       hs;
  logic       do_load;
  logic       do_first;
  logic       do_step;
  logic       do_fin;
  logic       do_abort;

  assign hs   = rk_valid & rk_ready;
  assign r_n  = r + 6'd1;
  assign busy = (state == LOAD) || (state == RUN);

  ravan_rc_lfsr #(
    .SEED (RC_SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_seed (do_load),
    .advance   (do_step | do_fin),
    .rc        (rc),
    .rc_next   (rc_next)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next state and datapath strobes; abort beats a handshake
  always_comb begin
    state_n  = state;
    do_load  = 1'b0;
    do_first = 1'b0;
    do_step  = 1'b0;
    do_fin   = 1'b0;
    do_abort = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          state_n = LOAD;
          do_load = 1'b1;
        end
      end
      LOAD: begin
        if (abort) begin
          state_n  = IDLE;
          do_abort = 1'b1;
        end else begin
          state_n  = RUN;
          do_first = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_n  = IDLE;
          do_abort = 1'b1;
        end else if (hs && rk_last) begin
          state_n = DONE;
          do_fin  = 1'b1;
        end else if (hs) begin
          do_step = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // slice bank, round counter and registered round key outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank     <= '0;
      r        <= '0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_index <= '0;
      rk_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= do_fin;
      if (do_load) begin
        bank <= key_slices;
        r    <= '0;
      end
      if (do_first) begin
        rk_valid <= 1'b1;
        rk_data  <= rotl64(bank[r[2:0]], r) ^ rc_mix(rc);
        rk_index <= r;
        rk_last  <= (r == LAST);
      end
      if (do_step) begin
        r        <= r_n;
        rk_data  <= rotl64(bank[r_n[2:0]], r_n) ^ rc_mix(rc_next);
        rk_index <= r_n;
        rk_last  <= (r_n == LAST);
      end
      if (do_fin || do_abort) begin
        rk_valid <= 1'b0;
        rk_last  <= 1'b0;
`ifdef RAVAN_KEY_ZEROIZE_EN
        bank     <= '0;
        rk_data  <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ravan_round_key_scheduler.sv
// Randomized self-checking bench for the round key scheduler.
// Expected keys come from a direct model of the key formula.
module tb_ravan_round_key_scheduler;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [511:0] key_slices = '0;
  logic         abort = 1'b0;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [63:0]  rk_data;
  logic [5:0]   rk_index;
  logic         rk_last;
  logic         done;

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] got_q[$];
  logic [63:0] ref_q[$];

  always #5 clk = ~clk;

  ravan_round_key_scheduler #(
    .NUM_ROUNDS (N),
    .RC_SEED    (8'h01)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .key_slices (key_slices),
    .abort      (abort),
    .busy       (busy),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_data    (rk_data),
    .rk_index   (rk_index),
    .rk_last    (rk_last),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_key(input logic [511:0] k,
                                          input int rnd);
    logic [7:0]  c;
    logic [63:0] s;
    logic [63:0] rot;
    int          sh;
    c = 8'h01;
    for (int i = 0; i < rnd; i++)
      c = {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
    s  = k[64*(rnd % 8) +: 64];
    sh = rnd % 64;
    if (sh == 0) rot = s;
    else rot = (s << sh) | (s >> (64 - sh));
    return rot ^ {c, 48'h0, c};
  endfunction

  function automatic logic [511:0] rnd_key();
    logic [511:0] k;
    for (int i = 0; i < 16; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // mode 0: always ready, 1: stall 3 cycles at index 2, 2: random ready
  task automatic run(input logic [511:0] k, input int mode,
                     input int abort_at, input int load_at,
                     input int rst_at);
    int  e;
    int  cyc;
    int  stall;
    bit  fin;
    bit  aborted;
    bit  rst_hit;
    bit  rdy;
    got_q.delete();
    e = 0; cyc = 0; stall = 0;
    fin = 0; aborted = 0; rst_hit = 0;
    @(negedge clk);
    load = 1'b1;
    key_slices = k;
    @(negedge clk);
    load = 1'b0;
    chk("load_busy", 64'(busy), 64'd1);
    chk("load_valid", 64'(rk_valid), 64'd0);
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      abort = 1'b0;
      load  = 1'b0;
      if (cyc == 1) chk("valid_rise", 64'(rk_valid), 64'd1);
      if (rk_valid) begin
        if (e == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_valid", 64'(rk_valid), 64'd0);
          chk("rst_data", rk_data, 64'd0);
          chk("rst_index", 64'(rk_index), 64'd0);
          chk("rst_busy", 64'(busy), 64'd0);
          chk("rst_last_done", 64'({rk_last, done}), 64'd0);
          rk_ready = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          rst_hit = 1;
          fin = 1;
        end else begin
          chk("rk_data", rk_data, ref_key(k, e));
          chk("rk_index", 64'(rk_index), 64'(e));
          chk("rk_last", 64'(rk_last), 64'(e == N - 1));
          chk("busy_run", 64'(busy), 64'd1);
          if (mode == 1 && e == 2 && stall < 3) begin
            rdy = 0;
            stall++;
          end else if (mode == 2) begin
            rdy = ($urandom_range(0, 3) != 0);
          end else begin
            rdy = 1;
          end
          rk_ready = rdy;
          if (e == load_at) begin
            load = 1'b1;
            key_slices = ~k;
          end
          if (rdy) begin
            got_q.push_back(rk_data);
            if (e == abort_at) begin
              abort = 1'b1;
              aborted = 1;
              fin = 1;
            end else if (e == N - 1) begin
              fin = 1;
            end
            e++;
          end
        end
      end else begin
        rk_ready = 1'($urandom);
      end
    end
    if (!fin) chk("timeout", 64'd1, 64'd0);
    if (!rst_hit) begin
      @(negedge clk);
      abort = 1'b0;
      load = 1'b0;
      rk_ready = 1'b0;
      chk("end_valid", 64'(rk_valid), 64'd0);
      chk("end_busy", 64'(busy), 64'd0);
      chk("end_done", 64'(done), aborted ? 64'd0 : 64'd1);
      @(negedge clk);
      chk("done_once", 64'(done), 64'd0);
      if (!aborted) begin
`ifdef RAVAN_KEY_ZEROIZE_EN
        chk("zero_data", rk_data, 64'd0);
        for (int i = 0; i < 8; i++)
          chk("zero_bank", dut.bank[i], 64'd0);
`else
        for (int i = 0; i < 8; i++)
          chk("keep_bank", dut.bank[i], k[64*i +: 64]);
`endif
      end
    end
  endtask

  initial begin
    logic [511:0] k;
    #12;
    chk("reset_outs", 64'({busy, rk_valid, rk_last, done}), 64'd0);
    chk("reset_data", rk_data, 64'd0);
    chk("reset_index", 64'(rk_index), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run('0, 0, -1, -1, -1);
    chk("zero_len", 64'(got_q.size()), 64'(N));
    chk("zero_rk0", got_q[0], 64'h0100_0000_0000_0001);
    chk("zero_rk1", got_q[1], 64'h0200_0000_0000_0002);

    k = '0;
    k[0] = 1'b1;
    run(k, 0, -1, -1, -1);
    chk("s0_rk0", got_q[0], 64'h0100_0000_0000_0000);
    chk("s0_rk8", got_q[8], ref_key('0, 8) ^ 64'h100);

    k = rnd_key();
    run(k, 0, -1, -1, -1);
    ref_q = got_q;
    run(k, 1, -1, -1, -1);
    chk("stall_len", 64'(got_q.size()), 64'(ref_q.size()));
    for (int i = 0; i < N; i++)
      chk("stall_same", got_q[i], ref_q[i]);

    run(rnd_key(), 2, 5, -1, -1);
    chk("abort_len", 64'(got_q.size()), 64'd6);
    run(rnd_key(), 2, -1, -1, -1);

    run(rnd_key(), 0, -1, 3, -1);
    chk("ldrun_len", 64'(got_q.size()), 64'(N));

    run(rnd_key(), 2, -1, -1, 7);
    run(rnd_key(), 0, -1, -1, -1);

    for (int t = 0; t < 4; t++)
      run(rnd_key(), 2, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ravan_round_key_scheduler.md
Name: ravan_round_key_scheduler

Overview:
- Sits directly downstream of the dynamic key slicer.
- Captures the slicer's eight 64-bit key slices into a local bank on a load request.
- Streams NUM_ROUNDS 64-bit round keys to the cipher datapath over a valid/ready handshake.
- Each round key is a rotated slice mixed with an LFSR round constant.

Parameters:
- NUM_ROUNDS, 16, number of round keys emitted per load (1..64).
- SLICE_W, 64, width of one slice and one round key (fixed at 64).
- NUM_SLICES, 8, slices per key (fixed at 8).
- RC_SEED, 8'h01, LFSR seed loaded on every accepted load (must be nonzero).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- load  in  1  start request; sampled only in IDLE.
- key_slices  in  512  flattened slices; slice i = key_slices[64*i+63 : 64*i].
- abort  in  1  terminate the current schedule.
- busy  out  1  high in LOAD and RUN.
- rk_valid  out  1  round key valid.
- rk_ready  in  1  consumer ready.
- rk_data  out  64  round key.
- rk_index  out  6  round number r of rk_data.
- rk_last  out  1  high with rk_valid when r == NUM_ROUNDS-1.
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset values: all outputs 0, state IDLE, slice bank 0, rc = RC_SEED, round counter 0.
- States and transitions:
  - IDLE -> LOAD on load=1.
  - LOAD -> RUN unconditionally.
  - RUN -> DONE on the handshake with rk_last=1.
  - DONE -> IDLE unconditionally.
- Load: in IDLE with load=1, bank <= key_slices, rc <= RC_SEED, r <= 0. load in any other state is ignored.
- Key generation: LOAD computes round key 0 into the output register. rk_valid rises in the cycle after LOAD, i.e. 2 cycles after load was sampled.
- Round key formula: rk(r) = ROTL64(bank[r mod 8], r mod 64) XOR {rc, 48'h0, rc}.
- Round constant LFSR (Fibonacci): fb = rc[7]^rc[5]^rc[4]^rc[3]; rc <= {rc[6:0], fb}. Advances once per handshake. The rc used for round r is the value after r advances.
- Handshake: a transfer occurs when rk_valid & rk_ready. While rk_valid=1 and rk_ready=0, rk_data, rk_index and rk_last hold stable.
- Throughput: on a transfer that is not the last, the next key is registered that same edge, giving 1 key/cycle under continuous ready.
- Final transfer: goes to DONE with rk_valid cleared. done=1 for exactly the DONE cycle, then IDLE.
- Abort: abort=1 in LOAD or RUN forces IDLE on the next edge. rk_valid=0, busy=0, done is NOT pulsed. abort has priority over a simultaneous handshake. abort in IDLE/DONE has no effect.
- Reset asserted mid-run: immediate return to reset values; no partial keys.
- Bank contents are not cleared on completion (see optional feature).

Optional Feature:
- Macro: RAVAN_KEY_ZEROIZE_EN.
- Defined: on entry to DONE and on abort, bank and rk_data are cleared to 0 in the same edge. rk_data reads 0 whenever rk_valid=0 after any run.
- Undefined: bank and rk_data retain their last values after DONE or abort.

Decomposition:
- Shared package ravan_key_pkg holds:
  - constants SLICE_W, NUM_SLICES, KEY_W=512 and RC_SEED default;
  - the state enum (IDLE, LOAD, RUN, DONE);
  - function rotl64(x, n).
- One natural sub-module: ravan_rc_lfsr (8-bit LFSR with load_seed and advance inputs).

Test Plan:
- All-zero key, rk_ready=1, NUM_ROUNDS=16 -> rk0=64'h0100_0000_0000_0001, rk1=64'h0200_0000_0000_0002; 16 back-to-back keys, rk_last on index 15; done pulses once, 1 cycle after.
- Slice0=64'h1, other slices 0 -> rk0=64'h0100_0000_0000_0000. rk8 slice0 rotated by 8 contributes 64'h100, XORed with the round-8 rc.
- rk_ready low for 3 cycles at index 2 -> rk_data/rk_index/rk_last stable; key sequence identical to the no-stall run.
- abort asserted at index 5, same cycle as a handshake -> IDLE next edge, rk_valid=0, no done. A new load then restarts at index 0 with rc=8'h01.
- load pulsed during RUN -> ignored, sequence unchanged. rst_n low at index 7 -> all outputs 0 immediately.
- With RAVAN_KEY_ZEROIZE_EN: after done, rk_data==0 and internal bank==0. Without it: bank equals the last loaded slices.
